shifter_pipe: RTL and testbench
===============================

Name: shifter_pipe

Overview:
Parametrised, pipelined barrel shifter for the datapath and FP-normalisation paths. It supports the four ARM shift modes (LSL, LSR, ASR, ROR) with full ARM carry-out semantics, including the special cases for shift amounts of 0, W and greater than W. Stages are log2-staged with a valid/ready handshake, backpressure and a pass-through tag. Throughput is one operation per cycle with fixed latency. It replaces fixed-width combinational shifters used for exponent/mantissa alignment.

Parameters:
W, 32, data width; power of two, minimum 8.
AMT_W, $clog2(W)+1, shift-amount width; must allow amounts up to 2W-1.
TAG_W, 4, width of sideband tag carried alongside each operation.

Ports:
CLK  in  1  clock, rising edge.
RESETn  in  1  synchronous active-low reset.
in_valid  in  1  input operation valid.
in_ready  out  1  block can accept an operation this cycle.
in_data  in  W  operand.
in_amt  in  AMT_W  unsigned shift amount.
in_mode  in  2  00=LSL, 01=LSR, 10=ASR, 11=ROR.
in_carry  in  1  current carry flag, used when the amount is 0.
in_tag  in  TAG_W  sideband, returned unchanged.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_data  out  W  shifted result.
out_carry  out  1  shifter carry-out.
out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (RESETn=0 at a rising edge) clears all stage valid bits.
  - out_valid=0, out_data=0, out_carry=0, out_tag=0.
  - Reset mid-stream discards every in-flight operation; no partial output.
  - in_ready is 1 in the first cycle after reset.
- Pipeline has L = log2(W)+1 register stages.
  - Stage 0 decodes: effective amount, special case, carry candidate.
  - Stages 1..log2(W) each conditionally shift by 2^(i-1).
  - The last stage register drives the outputs directly.
- Latency: an operation accepted at the edge ending cycle k has out_valid=1 in cycle k+L. For W=32, L=6.
- Handshake:
  - Transfer occurs when valid&&ready on the same edge.
  - Stage i advances iff stage i+1 is empty or stage i+1 is advancing.
  - in_ready = !stage0_valid || stage0_advancing.
  - Output stage advances when out_ready || !out_valid.
  - out_data, out_carry and out_tag are held stable while out_valid && !out_ready.
  - Bubbles collapse; no operation is dropped or duplicated; order is preserved.
- Simultaneous input accept and output drain on one edge is legal, giving a sustained rate of 1/cycle.
- Arithmetic rules (n = in_amt):
  - n=0, any mode: data unchanged; carry = in_carry.
  - LSL, 1<=n<W: data<<n; carry = in_data[W-n].
  - LSL, n=W: data 0; carry = in_data[0].
  - LSL, n>W: data 0; carry 0.
  - LSR, 1<=n<W: logical right shift; carry = in_data[n-1].
  - LSR, n=W: data 0; carry = in_data[W-1].
  - LSR, n>W: data 0; carry 0.
  - ASR, 1<=n<W: sign-filled right shift; carry = in_data[n-1].
  - ASR, n>=W: all bits = in_data[W-1]; carry = in_data[W-1].
  - ROR, n mod W != 0: rotate right by n mod W; carry = result[W-1].
  - ROR, n!=0 and n mod W = 0: data unchanged; carry = in_data[W-1].
- Special cases are resolved in stage 0 by forcing the effective amount and an override value. The shift stages only ever see amounts in 0..W-1.
- in_mode, in_amt and in_tag values are don't-care when in_valid=0; no state changes.

Decomposition:
- Package shifter_pkg holds:
  - mode constants SH_LSL, SH_LSR, SH_ASR, SH_ROR (2-bit);
  - the stage-payload struct: data, carry, mode, remaining-amount bits, tag, valid.
- One natural sub-module, shifter_stage: a single registered conditional shift by a parameter STEP with local valid/ready advance logic. It is instantiated log2(W) times in a generate loop.
- Stage 0 decode lives in the top module.

Test Plan:
- LSL 0x00000001 by 4, in_carry=1 -> out_data=0x00000010, out_carry=0 (in_data[28]); out_valid exactly 6 cycles after accept.
- LSR 0x80000000 by 32 -> 0x00000000, carry 1. ASR 0x80000000 by 40 -> 0xFFFFFFFF, carry 1. LSL 0x00000001 by 33 -> 0, carry 0.
- ROR 0x000000F1 by 4 -> 0x1000000F, carry 0. ROR 0x80000001 by 32 -> 0x80000001, carry 1. Any mode by 0 with in_carry=1 -> data unchanged, carry 1.
- Stream 10 back-to-back ops with tags 0..9 and out_ready=1 -> 10 results on consecutive cycles, tags in order.
- Same stream with out_ready low for 4 cycles mid-stream:
  - outputs are held stable;
  - in_ready drops once all 6 stages are full;
  - no loss or duplication; tags 0..9 in order.
- Assert RESETn=0 for one cycle with 3 ops in flight:
  - next cycle out_valid=0 and all outputs 0;
  - no stale result ever appears;
  - a new op is accepted immediately after.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
// The payload widths here set the datapath width that shifter_pipe is built for.
package shifter_pkg;

    localparam int unsigned SH_W     = 32;
    localparam int unsigned SH_LOG_W = $clog2(SH_W);
    localparam int unsigned SH_TAG_W = 4;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // amt holds the remaining shift; each stage consumes one bit of it
    typedef struct packed {
        logic                valid;
        logic [SH_TAG_W-1:0] tag;
        logic [1:0]          mode;
        logic [SH_LOG_W-1:0] amt;
        logic                carry;
        logic [SH_W-1:0]     data;
    } stage_t;

endpackage

// File: rtl/shifter_stage.sv
// One pipeline stage: registered conditional shift by STEP with local advance logic.
// Carry is final before this stage, so it is passed through untouched.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  stage_t prev_i,
    input  logic   next_ready_i,
    output stage_t stage_o,
    output logic   ready_o
);

    localparam int unsigned BIT = $clog2(STEP);

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d = prev_i;
        if (prev_i.amt[BIT]) begin
            unique case (prev_i.mode)
                SH_LSL: stage_d.data = prev_i.data << STEP;
                SH_LSR: stage_d.data = prev_i.data >> STEP;
                SH_ASR: stage_d.data = $unsigned($signed(prev_i.data) >>> STEP);
                SH_ROR: stage_d.data = (prev_i.data >> STEP) | (prev_i.data << (SH_W - STEP));
            endcase
        end
    end

    assign ready_o = !stage_q.valid || next_ready_i;

    // Payload only loads on a real transfer so a stalled or empty stage holds its value
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else if (ready_o) begin
            if (prev_i.valid) begin
                stage_q <= stage_d;
            end else begin
                stage_q.valid <= 1'b0;
            end
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with ARM carry-out semantics.
// Stage 0 resolves special amounts; log2(W) shift stages follow with valid/ready flow.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned W     = SH_W,
    parameter int unsigned AMT_W = $clog2(W) + 1,
    parameter int unsigned TAG_W = SH_TAG_W
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LOG = $clog2(W);

    stage_t         stage [LOG+1];
    logic           ready [LOG+2];
    stage_t         stage0_q;
    stage_t         dec_d;
    logic [LOG-1:0] amt_mod;
    logic [LOG-1:0] amt_m1;
    logic [LOG-1:0] amt_neg;
    logic           amt_ge_w;

    always_comb begin
        amt_mod  = in_amt[LOG-1:0];
        amt_ge_w = in_amt[AMT_W-1];
        amt_m1   = amt_mod - 1'b1;
        amt_neg  = ~amt_mod + 1'b1;  // W - amt_mod for non-zero amt_mod

        dec_d       = '0;
        dec_d.valid = 1'b1;
        dec_d.tag   = in_tag;
        dec_d.mode  = in_mode;
        dec_d.amt   = amt_mod;
        dec_d.data  = in_data;
        dec_d.carry = in_carry;

        if (in_amt != '0) begin
            unique case (in_mode)
                SH_LSL: begin
                    if (amt_ge_w) begin
                        dec_d.data  = '0;
                        dec_d.amt   = '0;
                        dec_d.carry = (amt_mod == '0) ? in_data[0] : 1'b0;
                    end else begin
                        dec_d.carry = in_data[amt_neg];
                    end
                end
                SH_LSR: begin
                    if (amt_ge_w) begin
                        dec_d.data  = '0;
                        dec_d.amt   = '0;
                        dec_d.carry = (amt_mod == '0) ? in_data[W-1] : 1'b0;
                    end else begin
                        dec_d.carry = in_data[amt_m1];
                    end
                end
                SH_ASR: begin
                    if (amt_ge_w) begin
                        dec_d.data  = {W{in_data[W-1]}};
                        dec_d.amt   = '0;
                        dec_d.carry = in_data[W-1];
                    end else begin
                        dec_d.carry = in_data[amt_m1];
                    end
                end
                SH_ROR: begin
                    // Bit W-1 of a rotate-right by r is in_data[r-1]
                    if (amt_mod == '0) begin
                        dec_d.carry = in_data[W-1];
                    end else begin
                        dec_d.carry = in_data[amt_m1];
                    end
                end
            endcase
        end
    end

    assign ready[0]    = !stage0_q.valid || ready[1];
    assign ready[LOG+1] = out_ready;
    assign in_ready    = ready[0];
    assign stage[0]    = stage0_q;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            stage0_q <= '0;
        end else if (ready[0]) begin
            if (in_valid) begin
                stage0_q <= dec_d;
            end else begin
                stage0_q.valid <= 1'b0;
            end
        end
    end

    for (genvar i = 1; i <= LOG; i++) begin : g_stage
        shifter_stage #(
            .STEP(1 << (i - 1))
        ) u_stage (
            .clk_i       (CLK),
            .rst_ni      (RESETn),
            .prev_i      (stage[i-1]),
            .next_ready_i(ready[i+1]),
            .stage_o     (stage[i]),
            .ready_o     (ready[i])
        );
    end

    assign out_valid = stage[LOG].valid;
    assign out_data  = stage[LOG].data;
    assign out_carry = stage[LOG].carry;
    assign out_tag   = stage[LOG].tag;

    logic unused_tail;
    assign unused_tail = ^{stage[LOG].mode, stage[LOG].amt};

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: reference model in plain wide arithmetic,
// randomized traffic with backpressure, plus directed corner and reset cases.
module tb_shifter_pipe;
    import shifter_pkg::*;

    localparam int W     = 32;
    localparam int AMT_W = 6;
    localparam int TAG_W = 4;
    localparam int L     = 6;

    logic             CLK = 1'b0;
    logic             RESETn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic [1:0]       in_mode = '0;
    logic             in_carry = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_data;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    shifter_pipe #(
        .W    (W),
        .AMT_W(AMT_W),
        .TAG_W(TAG_W)
    ) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .in_mode  (in_mode),
        .in_carry (in_carry),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_carry(out_carry),
        .out_tag  (out_tag)
    );

    typedef struct {
        logic [W-1:0]     data;
        logic             carry;
        logic [TAG_W-1:0] tag;
        int               acc_cyc;
        bit               chk_lat;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               passes = 0;
    int               cyc = 0;
    int               pop_cyc[16];
    bit               saw_stall = 1'b0;
    bit               rnd_done = 1'b0;
    logic             held_v = 1'b0;
    logic [W-1:0]     held_d;
    logic             held_c;
    logic [TAG_W-1:0] held_t;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Reference: shifts on a double-width word so the carry falls out as the adjacent bit
    function automatic void model(input logic [W-1:0] d, input int n, input logic [1:0] m,
                                  input logic c, output logic [W-1:0] rd, output logic rc);
        logic [2*W-1:0] x;
        int r;
        if (n == 0) begin
            rd = d;
            rc = c;
            return;
        end
        case (m)
            SH_LSL: begin
                x  = {{W{1'b0}}, d} << n;
                rd = x[W-1:0];
                rc = x[W];
            end
            SH_LSR: begin
                x  = {d, {W{1'b0}}} >> n;
                rd = x[2*W-1:W];
                rc = x[W-1];
            end
            SH_ASR: begin
                x  = $unsigned($signed({d, {W{1'b0}}}) >>> ((n > W) ? W : n));
                rd = x[2*W-1:W];
                rc = x[W-1];
            end
            default: begin
                r = n % W;
                if (r == 0) begin
                    rd = d;
                    rc = d[W-1];
                end else begin
                    rd = (d >> r) | (d << (W - r));
                    rc = rd[W-1];
                end
            end
        endcase
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (RESETn) begin
            if (held_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held_d);
                check("hold_carry", out_carry, held_c);
                check("hold_tag", out_tag, held_t);
            end
            if (in_valid && !in_ready) saw_stall = 1'b1;
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_c = out_carry;
            held_t = out_tag;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got tag %0h data %0h, required none",
                             out_tag, out_data);
                end else begin
                    e = sb.pop_front();
                    check("data", out_data, e.data);
                    check("carry", out_carry, e.carry);
                    check("tag", out_tag, e.tag);
                    if (e.chk_lat) check("latency", cyc - e.acc_cyc, L);
                    pop_cyc[out_tag] = cyc;
                end
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [AMT_W-1:0] n, input logic [1:0] m,
                        input logic c, input logic [TAG_W-1:0] t, input bit lat);
        exp_t e;
        logic [W-1:0] rd;
        logic rc;
        bit acc;
        model(d, int'(n), m, c, rd, rc);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = n;
        in_mode  = m;
        in_carry = c;
        in_tag   = t;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            acc = in_ready;
            if (acc) begin
                e = '{rd, rc, t, cyc, lat};
                sb.push_back(e);
            end
            @(posedge CLK);
            #1;
            if (acc) return;
        end
        checks++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required accept");
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_amt   = $urandom();
        in_mode  = $urandom();
        in_tag   = $urandom();
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && sb.size() != 0; k++) begin
            @(posedge CLK);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs();
        @(negedge CLK);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        int edge_amts[6] = '{0, 1, 31, 32, 33, 63};
        logic [AMT_W-1:0] a;

        repeat (2) @(posedge CLK);
        #1;
        RESETn = 1'b1;
        check_reset_outputs();
        @(posedge CLK);
        #1;

        // Directed corners, each isolated so latency is exact
        send(32'h0000_0001, 6'd4,  SH_LSL, 1'b1, 4'd0, 1'b1); idle(); drain();
        send(32'h8000_0000, 6'd32, SH_LSR, 1'b0, 4'd1, 1'b1); idle(); drain();
        send(32'h8000_0000, 6'd40, SH_ASR, 1'b0, 4'd2, 1'b1); idle(); drain();
        send(32'h0000_0001, 6'd33, SH_LSL, 1'b1, 4'd3, 1'b1); idle(); drain();
        send(32'h0000_00F1, 6'd4,  SH_ROR, 1'b1, 4'd4, 1'b1); idle(); drain();
        send(32'h8000_0001, 6'd32, SH_ROR, 1'b0, 4'd5, 1'b1); idle(); drain();
        send(32'h0000_0001, 6'd32, SH_LSL, 1'b0, 4'd6, 1'b1); idle(); drain();
        send(32'h1234_5678, 6'd1,  SH_LSR, 1'b0, 4'd7, 1'b1); idle(); drain();
        for (int m = 0; m < 4; m++) begin
            send(32'hA5A5_0F0F, 6'd0, 2'(m), 1'b1, 4'(8 + m), 1'b1);
            idle();
            drain();
        end

        // Back-to-back stream with the consumer always ready
        for (int t = 0; t < 10; t++) send($urandom(), 6'($urandom_range(0, 63)),
                                          2'($urandom()), 1'($urandom()), 4'(t), 1'b0);
        idle();
        drain();
        check("stream_span", pop_cyc[9] - pop_cyc[0], 9);

        // Same stream with a 4-cycle stall mid-stream
        saw_stall = 1'b0;
        fork
            begin
                for (int t = 0; t < 10; t++) send($urandom(), 6'($urandom_range(0, 63)),
                                                  2'($urandom()), 1'($urandom()), 4'(t), 1'b0);
                idle();
            end
            begin
                repeat (8) @(posedge CLK);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready_dropped", saw_stall, 1);

        // Reset with three ops in flight: none may surface afterwards
        send(32'hDEAD_BEEF, 6'd3, SH_LSL, 1'b0, 4'd1, 1'b0);
        send(32'hCAFE_F00D, 6'd5, SH_ROR, 1'b0, 4'd2, 1'b0);
        send(32'h0BAD_F00D, 6'd7, SH_ASR, 1'b0, 4'd3, 1'b0);
        idle();
        RESETn = 1'b0;
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        sb.delete();
        check_reset_outputs();
        @(posedge CLK);
        #1;
        send(32'h0000_0F00, 6'd8, SH_LSR, 1'b1, 4'd7, 1'b1);
        idle();
        drain();
        repeat (10) @(posedge CLK);
        #1;

        // Randomized traffic with random consumer stalls
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) a = 6'(edge_amts[$urandom_range(0, 5)]);
                    else a = 6'($urandom_range(0, 63));
                    send($urandom(), a, 2'($urandom()), 1'($urandom()), 4'(i), 1'b0);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        repeat ($urandom_range(1, 3)) @(posedge CLK);
                        #1;
                    end
                end
                idle();
                drain();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge CLK);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0) || rnd_done;
                end
                out_ready = 1'b1;
            end
        join

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
